switch_debounce: RTL and testbench
==================================

Name: switch_debounce

Overview:
- Input conditioning stage that sits directly upstream of the lab top-level logic (stair light, half adder, 2-bit ripple adder).
- Takes the 8 raw board slide switches, synchronises each into the clock domain, and debounces each bit independently.
- Presents glitch-free levels on `sw_clean`, which the downstream logic consumes in place of the raw switches.
- Also produces one-cycle rise and fall strobes per bit for future sequential consumers.

Parameters:
- WIDTH, 8, number of independent switch channels.
- CNT_MAX, 1000000, cycles a synchronised input must hold a new value before acceptance (10 ms at 100 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 20, width of each per-bit stability counter; must satisfy CNT_MAX-1 < 2^CNT_W.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  WIDTH  asynchronous raw switch levels.
- sw_clean  output  WIDTH  debounced registered switch levels.
- sw_rise  output  WIDTH  one-cycle pulse when corresponding `sw_clean` bit goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse when corresponding `sw_clean` bit goes 1->0.
- sw_changed  output  1  registered OR of (`sw_rise` | `sw_fall`), asserted in the same cycle as those pulses.

Behaviour:
- One clock domain. Reset is synchronous, active-high, and acts on the rising clk edge where `rst`=1.
- Reset state:
  - `sync0`, `sync1`, `sw_clean`, `sw_rise`, `sw_fall`, `sw_changed` = 0.
  - All counters = 0.
- Synchroniser, per bit: `sync0` <= `sw_raw`; `sync1` <= `sync0`. Only `sync1` feeds the debounce logic.
- Per-bit debounce, evaluated every non-reset edge (bits fully independent):
  - If `sync1[i]` == `sw_clean[i]`: `cnt[i]` <= 0; rise/fall[i] <= 0.
  - Else if `cnt[i]` == CNT_MAX-1: `sw_clean[i]` <= `sync1[i]`; `cnt[i]` <= 0; `sw_rise[i]` <= `sync1[i]`; `sw_fall[i]` <= ~`sync1[i]`.
  - Else: `cnt[i]` <= `cnt[i]`+1; rise/fall[i] <= 0.
- Latency:
  - `sw_raw` change set up before edge 1 -> `sync1` valid after edge 2 -> `sw_clean` and strobe update at edge 2+CNT_MAX.
  - With CNT_MAX=1, `sw_clean` updates at edge 3.
- Glitch rejection:
  - Any return of `sync1[i]` to the `sw_clean[i]` value before acceptance clears `cnt[i]`; no output change, no strobe.
  - A `sync1` excursion lasting exactly CNT_MAX cycles is accepted; CNT_MAX-1 cycles is rejected.
- Strobes:
  - High for exactly one cycle per accepted transition.
  - Never both `sw_rise[i]` and `sw_fall[i]` high.
  - Consecutive accepted transitions on one bit are at least CNT_MAX cycles apart.
- Simultaneous events: multiple bits may accept in the same cycle; each asserts its own strobe, and `sw_changed` is asserted once.
- Reset mid-operation:
  - Counting is abandoned and `sw_clean` is forced to 0 even if switches are high.
  - After `rst` deasserts, a held-high switch is re-accepted 2+CNT_MAX edges later with a `sw_rise` pulse.
- Counter never exceeds CNT_MAX-1; no wrap-around is possible.
- No combinational path from `sw_raw` to any output.

Test Plan:
- Reset, `sw_raw`=8'hFF held, CNT_MAX=4 -> during reset all outputs 0.
- Release reset with `sw_raw`=8'hFF still held, CNT_MAX=4 -> at post-reset edge 6: `sw_clean`=8'hFF, `sw_rise`=8'hFF and `sw_changed`=1 for one cycle, then 0.
- CNT_MAX=4, `sw_clean`=0, `sw_raw[3]` pulsed high for 3 cycles -> `sw_clean` stays 8'h00, no strobes. Repeat with a 4-cycle pulse -> `sw_clean[3]`=1 for 4 cycles, single `sw_rise[3]`, later single `sw_fall[3]`.
- CNT_MAX=4, `sw_raw[0]` bounces 1,0,1,0,1 (1 cycle each), then holds 1 -> exactly one `sw_rise[0]`, 6 edges after the final 0->1 transition.
- CNT_MAX=4, `sw_clean`=8'h0F, `sw_raw` set to 8'hF0 in one cycle -> 6 edges later `sw_clean`=8'hF0, `sw_rise`=8'hF0, `sw_fall`=8'h0F, `sw_changed`=1, all in the same cycle.
- CNT_MAX=4, `rst` asserted for 1 cycle while `cnt[5]`=2 with `sw_raw[5]`=1 -> `sw_clean[5]` forced 0, then re-accepted with `sw_rise[5]` 6 edges after reset release.

Source files
------------

// File: rtl/switch_debounce.sv
// switch_debounce: conditions the raw board slide switches for downstream logic.
// Each switch bit passes through a two-flop synchroniser and then through its
// own debounce counter. A synchronised level that differs from the current
// clean level must be seen for CNT_MAX consecutive edges before it is accepted.
// Each accepted transition produces a one-cycle rise or fall strobe, and
// sw_changed is raised in the same cycle.
//
// Interface behaviour: there is no handshake. Every output is a plain register
// and is valid on every cycle. Strobes last exactly one clock, and there is no
// combinational path from sw_raw to any output.
module switch_debounce #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  // Terminal count: when a differing sample arrives while the counter holds
  // this value, the run has reached CNT_MAX samples and is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] r_sync0;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_clean;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_differ;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_clean_nxt;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;

  // Two-flop synchroniser. Only r_sync1 is used by the debounce logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
    end else begin
      r_sync0 <= sw_raw;
      r_sync1 <= r_sync0;
    end
  end

  // Per-bit acceptance decision: the level differs and the run is complete.
  always_comb begin
    w_differ = r_sync1 ^ r_clean;
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_differ[i] && (r_cnt[i] == CNT_LAST);
    end
    // An accepted bit flips. Its direction is taken from the synchronised level.
    w_clean_nxt = r_clean ^ w_accept;
    w_rise_nxt  = w_accept & r_sync1;
    w_fall_nxt  = w_accept & ~r_sync1;
  end

  // Per-bit stability counters. Each counter clears when the level agrees
  // with the clean level or when a transition is accepted, so it never
  // passes CNT_LAST.
  for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
    // Count consecutive differing samples for this bit.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt[g] <= '0;
      end else if (!w_differ[g] || w_accept[g]) begin
        r_cnt[g] <= '0;
      end else begin
        r_cnt[g] <= r_cnt[g] + CNT_W'(1);
      end
    end
  end

  // Register the clean levels, the strobes and the combined change flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clean   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_clean   <= w_clean_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= |w_accept;
    end
  end

  assign sw_clean   = r_clean;
  assign sw_rise    = r_rise;
  assign sw_fall    = r_fall;
  assign sw_changed = r_changed;

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce, run with CNT_MAX=4 and a narrow counter.
// A behavioural model derives the expected outputs from a sliding window of
// synchronised samples. Table vectors, hand-written corner sequences and random
// traffic are all compared against it through an expected queue.
module tb_switch_debounce;

  localparam int W    = 8;
  localparam int CMAX = 4;
  localparam int SBW  = 3 * W + 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int n_vec;
  int n_err;
  int cyc;

  logic [SBW-1:0] exp_q[$];

  // Model state: the synchroniser delay line, the last CMAX synchronised
  // samples, the samples seen per bit since the last accept or reset, and
  // the model's clean level.
  logic [W-1:0] m_dly[$];
  logic [W-1:0] m_win[$];
  int           m_since[W];
  logic [W-1:0] m_clean;

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } vec_t;

  vec_t tbl[11];

  switch_debounce #(.WIDTH(W), .CNT_MAX(CMAX), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A bit is accepted when all of the last CMAX synchronised samples differ
  // from its clean level, and all of those samples arrived after its last
  // accept or reset.
  task automatic model_step(input logic r, input logic [W-1:0] raw);
    logic [W-1:0] samp;
    logic [W-1:0] acc;
    logic         all_diff;
    if (r) begin
      m_dly = '{W'(0), W'(0)};
      m_win.delete();
      for (int b = 0; b < W; b++) m_since[b] = 0;
      m_clean = '0;
      exp_q.push_back('0);
      return;
    end
    samp = m_dly.pop_front();
    m_dly.push_back(raw);
    m_win.push_back(samp);
    if (m_win.size() > CMAX) void'(m_win.pop_front());
    acc = '0;
    for (int b = 0; b < W; b++) begin
      m_since[b]++;
      if (m_since[b] >= CMAX) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == m_clean[b]) all_diff = 1'b0;
        acc[b] = all_diff;
      end
      if (acc[b]) m_since[b] = 0;
    end
    m_clean = m_clean ^ acc;
    exp_q.push_back({m_clean, acc & samp, acc & ~samp, |acc});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic sb_check();
    logic [SBW-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("sb", 32'({sw_clean, sw_rise, sw_fall, sw_changed}), 32'(e));
  endtask

  // ---------------- driver ----------------
  // Drive the inputs, take one rising edge, step the model, then sample the
  // DUT 1 ns after the edge.
  task automatic tick(input logic r, input logic [W-1:0] raw);
    rst    = r;
    sw_raw = raw;
    @(posedge clk);
    model_step(r, raw);
    #1;
    cyc++;
    sb_check();
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, raw);
  endtask

  // ---------------- test ----------------
  initial begin
    int       rises;
    int       falls;
    int       hi_cyc;
    int       rise_at;
    logic [W-1:0] cur;
    logic     r;
    int       sel;

    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    rst     = 1'b1;
    sw_raw  = '0;
    m_dly   = '{W'(0), W'(0)};
    m_clean = '0;
    for (int b = 0; b < W; b++) m_since[b] = 0;

    // Reset with all switches held high, then release and expect acceptance
    // at post-reset edge 2+CMAX.
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
    for (int i = 3; i < 8; i++) tbl[i] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1};
    tbl[9]  = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].rst, tbl[i].raw);
      check($sformatf("tbl[%0d]", i), 32'({sw_clean, sw_rise, sw_fall, sw_changed}),
            32'({tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].chg}));
    end

    // Settle all switches low.
    hold(8'h00, 10);
    check("settle_low", 32'(sw_clean), 32'h00);

    // A 3-cycle pulse on bit 3 is rejected.
    rises = 0; hi_cyc = 0;
    for (int i = 0; i < 13; i++) begin
      tick(1'b0, (i < 3) ? 8'h08 : 8'h00);
      if (sw_rise[3]) rises++;
      if (sw_clean != 8'h00) hi_cyc++;
    end
    check("pulse3_rise", 32'(rises), 32'd0);
    check("pulse3_clean", 32'(hi_cyc), 32'd0);

    // A 4-cycle pulse on bit 3 is accepted for exactly 4 cycles.
    rises = 0; falls = 0; hi_cyc = 0;
    for (int i = 0; i < 18; i++) begin
      tick(1'b0, (i < 4) ? 8'h08 : 8'h00);
      if (sw_rise[3]) rises++;
      if (sw_fall[3]) falls++;
      if (sw_clean[3]) hi_cyc++;
    end
    check("pulse4_rise", 32'(rises), 32'd1);
    check("pulse4_fall", 32'(falls), 32'd1);
    check("pulse4_high", 32'(hi_cyc), 32'd4);

    // Bit 0 bounces 1,0,1,0,1, then holds 1. Expect one rise 6 edges after
    // the final 0->1 (that edge is tick index 4).
    rises = 0; rise_at = -1;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, (i < 5) ? ((i % 2 == 0) ? 8'h01 : 8'h00) : 8'h01);
      if (sw_rise[0]) begin
        rises++;
        rise_at = i;
      end
    end
    check("bounce_rise_cnt", 32'(rises), 32'd1);
    check("bounce_rise_at", 32'(rise_at), 32'd9);

    // Simultaneous accept: 0F -> F0.
    hold(8'h0F, 10);
    check("pre_0f", 32'(sw_clean), 32'h0F);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'hF0);
      if (i == 4) check("simul_before", 32'({sw_clean, sw_changed}), 32'({8'h0F, 1'b0}));
      if (i == 5) check("simul_at", 32'({sw_clean, sw_rise, sw_fall, sw_changed}),
                        32'({8'hF0, 8'hF0, 8'h0F, 1'b1}));
      if (i == 6) check("simul_after", 32'({sw_rise, sw_fall, sw_changed}), 32'd0);
    end

    // Reset while cnt[5] is 2, with bit 0 already accepted high.
    hold(8'h01, 10);
    check("pre_rst", 32'(sw_clean), 32'h01);
    hold(8'h21, 4);
    tick(1'b1, 8'h21);
    check("rst_force0", 32'({sw_clean, sw_rise, sw_fall, sw_changed}), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h21);
      if (i == 4) check("rerise_before", 32'(sw_clean), 32'h00);
      if (i == 5) check("rerise_at", 32'({sw_clean, sw_rise, sw_changed}),
                        32'({8'h21, 8'h21, 1'b1}));
    end

    // Random traffic: whole-byte changes, single-bit glitches and
    // occasional resets.
    cur = 8'h21;
    for (int i = 0; i < 900; i++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) cur = 8'($urandom);
      else if (sel < 4) cur = cur ^ (8'h01 << $urandom_range(0, 7));
      r = ($urandom_range(0, 199) == 0);
      tick(r, cur);
      if ((sw_rise & sw_fall) != 8'h00) check("rise_and_fall", 32'(sw_rise & sw_fall), 32'd0);
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
